// File: rtl/uart_pkg.sv
// Shared types and defaults for the arbitrated UART transmitter.
// The PARITY state only exists when UART_TX_ARBITER_PARITY_EN is defined.
package uart_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_STOP_BITS = 1;
  localparam int NUM_REQ       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_START,
    ST_DATA,
`ifdef UART_TX_ARBITER_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/tick_generator.sv
// Free-running divider producing a one-cycle pulse every DIV clocks.
// Used as the baud-rate source for the UART transmitter.
module tick_generator #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Frame serializer: shift register, bit counter and line state machine.
// Optional even-parity bit under UART_TX_ARBITER_PARITY_EN.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              tx,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  cnt;
`ifdef UART_TX_ARBITER_PARITY_EN
  logic              parity;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load)      state_nxt = ST_ALIGN;
      ST_ALIGN: if (baud_tick) state_nxt = ST_START;
      ST_START: if (baud_tick) state_nxt = ST_DATA;
`ifdef UART_TX_ARBITER_PARITY_EN
      ST_DATA:   if (baud_tick && cnt == DATA_LAST) state_nxt = ST_PARITY;
      ST_PARITY: if (baud_tick)                     state_nxt = ST_STOP;
`else
      ST_DATA:   if (baud_tick && cnt == DATA_LAST) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (baud_tick && cnt == STOP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The counter is reused for stop periods; it is cleared on every exit so it never wraps mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift  <= '0;
      cnt    <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (load) begin
          shift  <= load_data;
          cnt    <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
          parity <= ^load_data;
`endif
        end
        ST_DATA: if (baud_tick) begin
          shift <= shift >> 1;
          cnt   <= (cnt == DATA_LAST) ? '0 : cnt + 1'b1;
        end
        ST_STOP: if (baud_tick) begin
          cnt <= (cnt == STOP_LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state != ST_IDLE);
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift[0];
`ifdef UART_TX_ARBITER_PARITY_EN
      ST_PARITY: tx = parity;
`endif
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a UART transmitter; ready pulses only while idle.
// Define UART_TX_ARBITER_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           baud_tick_in,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic                           tx_out,
  output logic                           busy_out,
  output logic                           grant_out
);

  logic last_grant;
  logic winner;
  logic accept;
  logic busy;

  // With both requesting, the one that did not win last time goes next.
  always_comb begin
    winner        = (&req_valid_in) ? ~last_grant : ~req_valid_in[0];
    accept        = (|req_valid_in) && !busy && !rst_in;
    req_ready_out = '0;
    if (accept) req_ready_out[winner] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= 1'b1;
      grant_out  <= 1'b0;
    end else if (accept) begin
      last_grant <= winner;
      grant_out  <= winner;
    end
  end

  uart_tx_serializer #(
    .DATA_W    (DATA_W),
    .STOP_BITS (STOP_BITS)
  ) u_ser (
    .clk       (clk_in),
    .rst       (rst_in),
    .baud_tick (baud_tick_in),
    .load      (accept),
    .load_data (req_data_in[winner]),
    .tx        (tx_out),
    .busy      (busy)
  );

  assign busy_out = busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int DW  = 8;
  localparam int SB  = 1;
  localparam int DIV = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick;
  logic [1:0][DW-1:0]  req_data;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic                tx, busy, grant;

  int checks = 0;
  int errors = 0;
  int m_last = 1;
  int last_wait = 0;

  always #5 clk = ~clk;

  tick_generator #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  uart_tx_arbiter #(.DATA_W(DW), .STOP_BITS(SB)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .baud_tick_in  (tick),
    .req_data_in   (req_data),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .tx_out        (tx),
    .busy_out      (busy),
    .grant_out     (grant)
  );

  // Ready must be one-hot at most and only while idle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (req_ready === 2'b11 || (req_ready !== 2'b00 && busy !== 1'b0)) begin
        errors++;
        $display("FAIL ready_excl: ready=%b busy=%b, required at most one bit and only when idle", req_ready, busy);
      end
    end
  end

  function automatic logic [1:0] onehot(input int i);
    onehot = 2'(1 << i);
  endfunction

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (3) step;
    rst = 1'b0;
    m_last = 1;
    step;
  endtask

  // Waits for an accept, then checks the whole frame against the model.
  task automatic send_frame(input string tag, input bit keep);
    int waited;
    int g;
    int len;
    int bad;
    bit tk;
    logic [DW-1:0] d;
    logic lv[$];
    waited = 0;
    #1;
    while (req_ready === 2'b00 && waited < 600) begin
      step;
      waited++;
    end
    last_wait = waited;
    if (req_ready === 2'b00) begin
      checks++; errors++;
      $display("FAIL %s_timeout: ready=%b after %0d cycles, required a handshake", tag, req_ready, waited);
      return;
    end
    g = (req_valid == 2'b11) ? 1 - m_last : (req_valid[0] ? 0 : 1);
    checks++;
    if (req_ready !== onehot(g)) begin
      errors++;
      $display("FAIL %s_ready: ready=%b required %b", tag, req_ready, onehot(g));
    end
    d = req_data[g];
    tk = tick;
    m_last = g;
    step;
    if (keep) req_data[g] = DW'($urandom);
    else      req_valid[g] = 1'b0;
    checks++;
    if (grant !== g[0] || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_grant: grant=%b busy=%b required grant=%0d busy=1", tag, grant, busy, g);
    end
    len = 0;
    while (tx === 1'b1 && len < 2 * DIV) begin
      len++;
      step;
    end
    checks++;
    if (tk ? (len != DIV) : (len < 1 || len >= DIV)) begin
      errors++;
      $display("FAIL %s_align: align=%0d cycles, tick_at_accept=%0b, period=%0d", tag, len, tk, DIV);
    end
    lv.push_back(1'b0);
    for (int b = 0; b < DW; b++) lv.push_back(d[b]);
`ifdef UART_TX_ARBITER_PARITY_EN
    lv.push_back(^d);
`endif
    for (int s = 0; s < SB; s++) lv.push_back(1'b1);
    foreach (lv[i]) begin
      bad = 0;
      for (int k = 0; k < DIV; k++) begin
        if (tx !== lv[i]) bad++;
        step;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_bit%0d: %0d of %0d samples differ, required level %b (byte %h)", tag, i, bad, DIV, lv[i], d);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: busy=%b required 0 after stop", tag, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    step; step;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL rst_tx: tx=%b required 1", tx); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: busy=%b required 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: ready=%b required 00", req_ready); end
    checks++; if (grant !== 1'b0)    begin errors++; $display("FAIL rst_grant: grant=%b required 0", grant); end
    req_valid = 2'b00;
    rst = 1'b0;
    m_last = 1;
    step;
  endtask

  task automatic test_single;
    req_data[0] = 8'hA5;
    req_valid = 2'b01;
    send_frame("single", 1'b0);
  endtask

  task automatic test_contention;
    do_reset;
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    req_valid = 2'b11;
    send_frame("cont0", 1'b0);
    send_frame("cont1", 1'b0);
    checks++;
    if (last_wait != 0) begin
      errors++;
      $display("FAIL cont_gap: second accept after %0d idle cycles, required 0", last_wait);
    end
  endtask

  task automatic test_back_to_back;
    req_data[0] = DW'($urandom);
    req_data[1] = DW'($urandom);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      send_frame("b2b", 1'b1);
      if (i > 0) begin
        checks++;
        if (last_wait != 0) begin
          errors++;
          $display("FAIL b2b_gap: frame %0d waited %0d cycles, required 0", i, last_wait);
        end
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 20)) step;
      if (req_valid == 2'b00) begin
        req_data[0] = DW'($urandom);
        req_data[1] = DW'($urandom);
        req_valid = 2'($urandom_range(1, 3));
      end
      send_frame("rand", 1'b0);
    end
    for (int k = 0; k < 2; k++)
      if (req_valid != 2'b00) send_frame("drain", 1'b0);
  endtask

  task automatic test_tick_coincide;
    int n;
    n = 0;
    while (!(tick === 1'b1 && busy === 1'b0) && n < 100) begin
      step;
      n++;
    end
    checks++;
    if (!(tick === 1'b1 && busy === 1'b0)) begin
      errors++;
      $display("FAIL tick_sync: tick=%b busy=%b, required an idle tick cycle", tick, busy);
    end
    req_data[0] = DW'($urandom);
    req_valid = 2'b01;
    send_frame("tickco", 1'b0);
  endtask

  task automatic test_parity;
    req_data[1] = 8'h07;
    req_valid = 2'b10;
    send_frame("par07", 1'b0);
    req_data[1] = 8'h03;
    req_valid = 2'b10;
    send_frame("par03", 1'b0);
  endtask

  task automatic test_reset_mid;
    int n;
    int bad;
    req_data[1] = 8'hF0;
    req_valid = 2'b10;
    #1;
    n = 0;
    while (req_ready === 2'b00 && n < 300) begin step; n++; end
    step;
    req_valid = 2'b00;
    n = 0;
    while (tx === 1'b1 && n < 3 * DIV) begin step; n++; end
    repeat (4 * DIV + 2) step;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || grant !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: tx=%b busy=%b grant=%b required 0,1,1 in data bit 3", tx, busy, grant);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_tx: tx=%b required 1 right after reset", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: busy=%b required 0", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL mid_grant: grant=%b required 0", grant); end
    step; step;
    rst = 1'b0;
    m_last = 1;
    bad = 0;
    for (int k = 0; k < 4 * DIV; k++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      step;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_resume: %0d cycles active after reset, required line idle", bad);
    end
    req_data[0] = DW'($urandom);
    req_data[1] = DW'($urandom);
    req_valid = 2'b11;
    send_frame("post_rst0", 1'b0);
    send_frame("post_rst1", 1'b0);
  endtask

  initial begin
    req_valid = 2'b00;
    req_data  = '0;
    test_reset;
    test_single;
    test_contention;
    test_back_to_back;
    test_random;
    test_tick_coincide;
    test_parity;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, sent LSB first.
REQ-002 Parameter STOP_BITS, default 1: number of stop bit periods, legal values 1 or 2.
REQ-003 Port clk_in, input, 1: system clock (100 MHz).
REQ-004 Port rst_in, input, 1: reset, asynchronous, active-high.
REQ-005 Port baud_tick_in, input, 1: one-cycle pulse per bit period, from tick_generator.
REQ-006 Port req_data_in, input, 2xDATA_W: byte from requester i, in slice [i].
REQ-007 Port req_valid_in, input, 2: requester i offers a byte.
REQ-008 Port req_ready_out, output, 2: requester i byte accepted this cycle.
REQ-009 Port tx_out, output, 1: serial line, idle high.
REQ-010 Port busy_out, output, 1: a frame is in progress (state not IDLE).
REQ-011 Port grant_out, output, 1: index of the requester owning the current or last frame.

Function
REQ-012 States: IDLE, ALIGN, START, DATA, [PARITY], STOP.
REQ-013 IDLE: tx_out=1.
- If any req_valid_in is set, arbitrate, pulse req_ready_out[winner] for exactly one cycle, latch req_data_in[winner] into the shift register, set grant_out=winner, go to ALIGN.
REQ-014 Arbitration is round-robin: with both valid, the winner is the index not equal to last_grant; with one valid, that one wins.
REQ-015 ALIGN: tx_out=1; go to START on the next baud_tick_in. Every emitted bit therefore lasts exactly one full baud period.
REQ-016 START: tx_out=0; go to DATA on baud_tick_in.
REQ-017 DATA: tx_out=shift[0].
- Each baud_tick_in shifts right and increments the bit counter.
- After DATA_W ticks, go to PARITY if compiled in (REQ-025), else STOP.
REQ-018 STOP: tx_out=1 for STOP_BITS baud periods, then IDLE.
- A new handshake is possible in the first IDLE cycle, so the worst-case idle gap between frames is one ALIGN period.
REQ-019 req_ready_out is asserted only in IDLE.
- Both bits are never set in the same cycle.
- A valid that drops before it is accepted is ignored; no byte is lost once ready was pulsed.
REQ-020 baud_tick_in in IDLE is ignored.
- A baud_tick_in in the same cycle as the accept is not counted for ALIGN; ALIGN waits for a later tick.
REQ-021 The bit counter is clog2(DATA_W+1) bits wide and saturates by state change, never wrapping within a frame.

Reset
REQ-022 While rst_in=1 (at any time, including mid-frame):
- State=IDLE, tx_out=1, busy_out=0, req_ready_out=0, grant_out=0.
- last_grant=1, so requester 0 wins the first contention.
- Shift register and counter are cleared.
REQ-023 An aborted frame is not resumed; the line returns high immediately.

Configuration
REQ-024 Macro UART_TX_ARBITER_PARITY_EN controls the parity bit.
REQ-025 With the macro defined, PARITY follows DATA and drives even parity (XOR of the latched byte) for one baud period.
REQ-026 Without the macro, the PARITY state, its logic and its register do not exist, and DATA goes directly to STOP.

Structure
REQ-027 Shared package uart_pkg holds:
- the tx state enum;
- the default DATA_W and STOP_BITS constants;
- the requester-count constant NUM_REQ=2.
REQ-028 Sub-module uart_tx_serializer holds the shift register, bit counter and tx_out state machine.
- The top level holds only the round-robin arbiter, last_grant and the handshake.

Verification
REQ-029 The bench shall use tick_generator as the baud_tick_in source, and shall cover:
- Single byte: req0 sends 0xA5 with DATA_W=8 and no parity. tx_out shows 0,1,0,1,0,0,1,0,1,1, each bit exactly one baud period; busy_out falls after the stop bit.
- Contention after reset: both valid, req0=0x11, req1=0x22. req0 is accepted first and grant_out=0; req1 is accepted in the first IDLE after the stop bit, with grant_out=1.
- Continuous contention: both valid for four frames. Grants alternate 0,1,0,1 and req_ready_out is never 2'b11.
- Reset mid-DATA: assert rst_in after the third data bit. tx_out=1 within the same cycle (asynchronous), state IDLE, no resumption.
- Parity build: with UART_TX_ARBITER_PARITY_EN defined, byte 0x07 gives parity bit 1 and byte 0x03 gives parity bit 0, each one period, before the stop bit.
- Tick coincidence: baud_tick_in in the accept cycle. ALIGN lasts a full period, and the start bit is exactly one period long.
